aes_sbox_pipe: RTL and testbench
================================

Name: aes_sbox_pipe

Overview:
Parametrised, pipelined SubBytes engine. Applies the AES forward S-box or inverse S-box, selected per beat, to LANES independent bytes. Provides a valid/ready stream interface with full backpressure, bubble collapse and a sideband tag. It sits between the state/key-schedule datapath and the round controller, and serves both encryption and decryption cores.

Parameters:
LANES, 4, number of byte lanes processed per beat (1..16; 16 = full AES state, 4 = key-schedule word)
LATENCY, 1, register stages from input acceptance to output valid (1..3)
TAG_W, 4, width of the sideband tag carried alongside each beat (1..16)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat present
in_ready  output  1  block accepts beat this cycle
in_inv  input  1  0 = forward S-box, 1 = inverse S-box, per beat
in_data  input  8*LANES  input bytes; lane i = in_data[8i+7:8i]
in_tag  input  TAG_W  sideband, passed through unchanged
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts beat
out_data  output  8*LANES  substituted bytes, same lane order
out_inv  output  1  mode the beat was processed with
out_tag  output  TAG_W  tag of the beat

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Transfer rule: a transfer happens on a rising edge where valid && ready. out_valid is held once asserted. out_data, out_inv and out_tag are stable until out_ready is seen.
- Pipeline structure: LATENCY stages S1..SL, each with a valid bit and registers for data, inv and tag.
- Lookup placement: the lookup is combinational on in_data/in_inv and its result is registered into S1. Later stages only register.
- Stage advance: stage k loads when it is empty or when stage k+1 (or the output, for SL) transfers this cycle. This collapses bubbles.
- in_ready = !S1.valid || S1 advances. The ready path is combinational from out_ready through all stages; this is intentional.
- Latency: exactly LATENCY cycles from acceptance to out_valid when there is no backpressure.
- Throughput: one beat per cycle sustained when out_ready = 1.
- Lane mapping: lane i output = FWD[byte i] if inv = 0, else INV[byte i]. Lanes are fully independent. Table values per FIPS-197 (e.g. FWD[0x00] = 0x63, INV[0x63] = 0x00).
- Per-beat mode: in_inv can change every beat. Each beat keeps its own mode through the pipeline, and out_inv reflects it.
- Full condition: all stages valid and out_ready = 0. in_ready = 0 and no state changes. No beat is lost or duplicated.
- Simultaneous drain and fill: SL transfers out while a new beat is accepted in the same cycle. Both occur, and occupancy is unchanged.
- Reset values: all stage valid bits 0, out_valid 0, out_data 0, out_inv 0, out_tag 0. in_ready is 1 during the first cycle after reset release.
- Reset mid-operation: rst asserted while beats are in flight discards them all. Outputs take reset values on the next edge. in_valid is ignored while rst = 1.
- No X propagation: data registers are not required to clear when a stage empties. out_data is only meaningful when out_valid = 1. Reset clearing of all stage data registers is mandatory.

Decomposition:
- Package aes_sbox_pkg:
  - SBOX_FWD and SBOX_INV 256-entry byte constant tables.
  - Functions sbox_fwd(byte), sbox_inv(byte).
  - Localparam MAX_LANES = 16.
- Sub-module aes_sbox_lane: combinational single-byte forward/inverse lookup (byte in, inv in, byte out). Instantiated LANES times in a generate loop.
- Pipeline valid/advance control stays in the top module.

Test Plan:
- Forward, LANES=4, LATENCY=1: in_data=0x00_01_53_FF, inv=0, tag=0x5 -> one cycle later out_data=0x63_7C_ED_16, out_inv=0, out_tag=0x5.
- Inverse, LANES=4, LATENCY=2: in_data=0x63_7C_ED_16, inv=1 -> two cycles later out_data=0x00_01_53_FF. Also in_data=0x00 in lane 0 -> 0x52.
- Exhaustive round trip, LANES=16, LATENCY=3: stream all 256 byte values forward, then feed the results back inverse -> every byte returns to its original value. Back-to-back throughput is 1 beat/cycle.
- Backpressure with per-beat mode alternation: random out_ready (~50%) and random in_valid, with inv alternating fwd/inv every beat -> output sequence matches the reference model in order, with no drops or duplicates. out_data is stable while out_valid && !out_ready.
- Full/bubble: hold out_ready=0 until all LATENCY stages are full -> in_ready=0. Release for one cycle -> exactly one beat out and one beat in. Insert a single bubble and hold out_ready=0 -> the bubble collapses and the pipeline refills.
- Reset mid-stream: 3 beats in flight, assert rst one cycle -> next edge out_valid=0 and out_data=0. After release, in_ready=1 and a new beat 0x00 fwd -> 0x63 with no stale beats emitted.

Source files
------------

// File: rtl/aes_sbox_pkg.sv
// AES S-box constants and lookup helpers shared by the lane and pipeline modules.
// Tables are the FIPS-197 forward and inverse substitution boxes, indexed by byte value.
package aes_sbox_pkg;

  localparam int MAX_LANES = 16;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte S-box: purely combinational forward or inverse lookup.
module aes_sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  assign dout = inv ? sbox_inv(din) : sbox_fwd(din);

endmodule

// File: rtl/aes_sbox_pipe.sv
// Pipelined multi-lane SubBytes with valid/ready flow control, per-beat mode and tag.
// The lookup sits in front of stage 1; later stages are plain registers that collapse bubbles.
module aes_sbox_pipe
  import aes_sbox_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_inv,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int DW = 8 * LANES;

  if (LANES < 1 || LANES > MAX_LANES) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES out of range");
  end
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("aes_sbox_pipe: LATENCY out of range");
  end

  logic [DW-1:0] sub_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane u_lane (
      .din  (in_data[8*i +: 8]),
      .inv  (in_inv),
      .dout (sub_data[8*i +: 8])
    );
  end

  logic [LATENCY-1:0]             vld;
  logic [LATENCY-1:0]             ld;
  logic [LATENCY-1:0][DW-1:0]     dat;
  logic [LATENCY-1:0]             inv_q;
  logic [LATENCY-1:0][TAG_W-1:0]  tag_q;

  // Element k of each chain is what stage k loads from; element 0 is the lookup result.
  logic [LATENCY:0]               v_chain;
  logic [LATENCY:0][DW-1:0]       d_chain;
  logic [LATENCY:0]               i_chain;
  logic [LATENCY:0][TAG_W-1:0]    t_chain;

  assign v_chain = {vld, in_valid};
  assign d_chain = {dat, sub_data};
  assign i_chain = {inv_q, in_inv};
  assign t_chain = {tag_q, in_tag};

  // Stage k may load if empty or if everything downstream can move this cycle.
  logic down_ok;
  always_comb begin
    ld      = '0;
    down_ok = out_ready;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      down_ok = !vld[k] || down_ok;
      ld[k]   = down_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      dat   <= '0;
      inv_q <= '0;
      tag_q <= '0;
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        if (ld[k]) begin
          vld[k]   <= v_chain[k];
          dat[k]   <= d_chain[k];
          inv_q[k] <= i_chain[k];
          tag_q[k] <= t_chain[k];
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];
  assign out_inv   = inv_q[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Self-checking bench: table vectors on 4-lane pipes (latency 1 and 2) and a scoreboarded 16-lane
// latency-3 pipe checked against an S-box model derived from GF(2^8) inversion and the affine map.
module tb_aes_sbox_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-lane DUTs share stimulus
  logic        v1, inv1;
  logic [31:0] d1;
  logic [3:0]  t1;
  logic        ir_a, ov_a, oi_a, ir_b, ov_b, oi_b;
  logic [31:0] od_a, od_b;
  logic [3:0]  ot_a, ot_b;

  // 16-lane DUT
  logic         v3, inv3, ordy3;
  logic [127:0] d3;
  logic [7:0]   t3;
  logic         ir3, ov3, oi3;
  logic [127:0] od3;
  logic [7:0]   ot3;

  aes_sbox_pipe #(.LANES(4), .LATENCY(1), .TAG_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir_a), .in_inv(inv1), .in_data(d1), .in_tag(t1),
    .out_valid(ov_a), .out_ready(1'b1), .out_data(od_a), .out_inv(oi_a), .out_tag(ot_a));

  aes_sbox_pipe #(.LANES(4), .LATENCY(2), .TAG_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir_b), .in_inv(inv1), .in_data(d1), .in_tag(t1),
    .out_valid(ov_b), .out_ready(1'b1), .out_data(od_b), .out_inv(oi_b), .out_tag(ot_b));

  aes_sbox_pipe #(.LANES(16), .LATENCY(3), .TAG_W(8)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3), .in_inv(inv3), .in_data(d3), .in_tag(t3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_inv(oi3), .out_tag(ot3));

  typedef struct {
    logic [31:0] din;
    logic        inv;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic         inv;
    logic [7:0]   tag;
  } beat_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  beat_t exp_q[$];
  beat_t got_q[$];
  int    got_cyc[$];
  logic  armed = 1'b0;
  beat_t held;
  logic  in_acc = 1'b0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard for the 16-lane pipe, sampled mid-cycle when all inputs are settled.
  task automatic mon_step();
    beat_t e;
    if (rst) begin
      exp_q.delete();
      armed  = 1'b0;
      in_acc = 1'b0;
      return;
    end
    if (armed) begin
      chk("hold_valid", 128'(ov3), 128'(1'b1));
      chk("hold_data", od3, held.data);
      chk("hold_inv", 128'(oi3), 128'(held.inv));
      chk("hold_tag", 128'(ot3), 128'(held.tag));
    end
    in_acc = v3 && ir3;
    if (ov3 && ordy3) begin
      got_q.push_back('{od3, oi3, ot3});
      got_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra_beat: got %0h with nothing expected (cycle %0d)", od3, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", od3, e.data);
        chk("sb_inv", 128'(oi3), 128'(e.inv));
        chk("sb_tag", 128'(ot3), 128'(e.tag));
      end
    end
    armed = ov3 && !ordy3;
    held  = '{od3, oi3, ot3};
    if (in_acc) exp_q.push_back('{ref_sub(d3, inv3), inv3, t3});
  endtask

  task automatic tick();
    @(negedge clk);
    mon_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    v3    = 1'b0;
    ordy3 = 1'b1;
    repeat (8) tick();
  endtask

  vec_t vecs[6];

  initial begin
    int acc, lat, stall, base, n0;
    logic alt;
    logic [127:0] orig;

    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv, s;
      iv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      s = iv ^ rol(iv, 1) ^ rol(iv, 2) ^ rol(iv, 3) ^ rol(iv, 4) ^ 8'h63;
      fwd_m[x] = s;
      inv_m[s] = 8'(x);
    end

    vecs[0] = '{32'h0001_53FF, 1'b0, 4'h5, 32'h637C_ED16};
    vecs[1] = '{32'h637C_ED16, 1'b1, 4'hA, 32'h0001_53FF};
    vecs[2] = '{32'h0000_0000, 1'b1, 4'h3, 32'h5252_5252};
    vecs[3] = '{32'h0000_0000, 1'b0, 4'hC, 32'h6363_6363};
    vecs[4] = '{32'hFFFF_FFFF, 1'b1, 4'hF, 32'h7D7D_7D7D};
    vecs[5] = '{32'h1020_3040, 1'b0, 4'h1, 32'hCAB7_0409};

    v1 = 1'b0; inv1 = 1'b0; d1 = '0; t1 = '0;
    v3 = 1'b0; inv3 = 1'b0; d3 = '0; t3 = '0; ordy3 = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid_a", 128'(ov_a), 128'(1'b0));
    chk("rst_out_valid_c", 128'(ov3), 128'(1'b0));
    chk("rst_out_data_c", od3, 128'h0);
    chk("rst_out_tag_c", 128'(ot3), 128'h0);
    chk("rst_out_inv_c", 128'(oi3), 128'h0);
    chk("rst_in_ready_a", 128'(ir_a), 128'(1'b1));
    chk("rst_in_ready_c", 128'(ir3), 128'(1'b1));

    // table vectors: latency-1 result after one edge, latency-2 after two
    for (int i = 0; i < 6; i++) begin
      v1 = 1'b1; d1 = vecs[i].din; inv1 = vecs[i].inv; t1 = vecs[i].tag;
      tick();
      chk("vec_lat1_valid", 128'(ov_a), 128'(1'b1));
      chk("vec_lat1_data", 128'(od_a), 128'(vecs[i].exp));
      chk("vec_lat1_inv", 128'(oi_a), 128'(vecs[i].inv));
      chk("vec_lat1_tag", 128'(ot_a), 128'(vecs[i].tag));
      chk("vec_lat2_early", 128'(ov_b), 128'(1'b0));
      v1 = 1'b0;
      tick();
      chk("vec_lat2_valid", 128'(ov_b), 128'(1'b1));
      chk("vec_lat2_data", 128'(od_b), 128'(vecs[i].exp));
      chk("vec_lat2_inv", 128'(oi_b), 128'(vecs[i].inv));
      chk("vec_lat2_tag", 128'(ot_b), 128'(vecs[i].tag));
      chk("vec_lat1_drained", 128'(ov_a), 128'(1'b0));
    end

    // latency of the 3-stage pipe
    drain();
    v3 = 1'b1; d3 = rnd128(); inv3 = 1'b0; t3 = 8'h11;
    tick();
    v3 = 1'b0;
    lat = 1;
    while (!ov3 && lat < 10) begin tick(); lat++; end
    chk("latency3", 128'(lat), 128'(3));

    // exhaustive round trip: all 256 bytes forward, then the results inverse
    drain();
    stall = 0;
    base = got_q.size();
    for (int b = 0; b < 16; b++) begin
      v3 = 1'b1; inv3 = 1'b0; t3 = 8'(b);
      for (int l = 0; l < 16; l++) d3[8*l +: 8] = 8'(b * 16 + l);
      if (!ir3) stall++;
      tick();
    end
    v3 = 1'b0;
    for (int n = 0; n < 20 && got_q.size() < base + 16; n++) tick();
    chk("rt_fwd_count", 128'(got_q.size() - base), 128'(16));
    chk("rt_fwd_stalls", 128'(stall), 128'(0));
    if (got_q.size() >= base + 16) begin
      chk("rt_fwd_back_to_back", 128'(got_cyc[base + 15] - got_cyc[base]), 128'(15));
      n0 = got_q.size();
      stall = 0;
      for (int b = 0; b < 16; b++) begin
        v3 = 1'b1; inv3 = 1'b1; t3 = 8'(8'h80 + b);
        d3 = got_q[base + b].data;
        if (!ir3) stall++;
        tick();
      end
      v3 = 1'b0;
      for (int n = 0; n < 20 && got_q.size() < n0 + 16; n++) tick();
      chk("rt_inv_count", 128'(got_q.size() - n0), 128'(16));
      chk("rt_inv_stalls", 128'(stall), 128'(0));
      if (got_q.size() >= n0 + 16) begin
        for (int b = 0; b < 16; b++) begin
          for (int l = 0; l < 16; l++) orig[8*l +: 8] = 8'(b * 16 + l);
          chk("rt_roundtrip", got_q[n0 + b].data, orig);
        end
      end
    end

    // random backpressure, mode alternating per accepted beat
    drain();
    alt = 1'b0;
    for (int n = 0; n < 400; n++) begin
      v3 = 1'($urandom_range(0, 3) != 0);
      ordy3 = 1'($urandom_range(0, 1));
      inv3 = alt;
      d3 = rnd128();
      t3 = 8'($urandom);
      tick();
      if (in_acc) alt = ~alt;
    end
    drain();
    chk("bp_scoreboard_empty", 128'(exp_q.size()), 128'(0));

    // full pipe: no accept, then one out and one in on a single release
    drain();
    ordy3 = 1'b0; v3 = 1'b1; acc = 0;
    for (int n = 0; n < 10 && ir3; n++) begin
      d3 = rnd128(); inv3 = 1'(n); t3 = 8'(n);
      tick();
      acc++;
    end
    chk("full_accepts", 128'(acc), 128'(3));
    chk("full_in_ready", 128'(ir3), 128'(1'b0));
    tick();
    tick();
    chk("full_hold_ready", 128'(ir3), 128'(1'b0));
    chk("full_hold_count", 128'(exp_q.size()), 128'(3));
    n0 = got_q.size();
    ordy3 = 1'b1;
    #1;
    chk("release_ready_comb", 128'(ir3), 128'(1'b1));
    tick();
    ordy3 = 1'b0;
    #1;
    chk("release_one_out", 128'(got_q.size() - n0), 128'(1));
    chk("release_occupancy", 128'(exp_q.size()), 128'(3));
    chk("release_refull", 128'(ir3), 128'(1'b0));

    // bubble collapse while the output is stalled
    drain();
    ordy3 = 1'b0; v3 = 1'b1; d3 = rnd128(); inv3 = 1'b1; t3 = 8'hB0;
    tick();
    v3 = 1'b0;
    tick();
    v3 = 1'b1; acc = 0;
    for (int n = 0; n < 10 && ir3; n++) begin
      d3 = rnd128(); inv3 = 1'(n); t3 = 8'(8'hB1 + n);
      tick();
      acc++;
    end
    chk("bubble_accepts", 128'(acc), 128'(2));
    chk("bubble_occupancy", 128'(exp_q.size()), 128'(3));
    drain();

    // reset with beats in flight
    ordy3 = 1'b0; v3 = 1'b1;
    for (int n = 0; n < 3; n++) begin d3 = rnd128(); t3 = 8'(8'hC0 + n); tick(); end
    chk("pre_rst_valid", 128'(ov3), 128'(1'b1));
    rst = 1'b1;
    tick();
    chk("mid_rst_out_valid", 128'(ov3), 128'(1'b0));
    chk("mid_rst_out_data", od3, 128'h0);
    chk("mid_rst_out_tag", 128'(ot3), 128'h0);
    chk("mid_rst_out_inv", 128'(oi3), 128'h0);
    rst = 1'b0; v3 = 1'b0;
    #1;
    chk("post_rst_in_ready", 128'(ir3), 128'(1'b1));
    n0 = got_q.size();
    d3 = '0; inv3 = 1'b0; t3 = 8'h77; v3 = 1'b1; ordy3 = 1'b1;
    tick();
    v3 = 1'b0;
    lat = 1;
    while (!ov3 && lat < 10) begin tick(); lat++; end
    chk("post_rst_latency", 128'(lat), 128'(3));
    chk("post_rst_data", od3, {16{8'h63}});
    chk("post_rst_tag", 128'(ot3), 128'(8'h77));
    repeat (6) tick();
    chk("post_rst_single_beat", 128'(got_q.size() - n0), 128'(1));
    chk("final_scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
